// File: rtl/serv_bufreg_w.sv
// rtl/serv_bufreg_w.sv - bit-serial address/operand buffer with inline W-bit adder
//
// Ports:
//   i_clk        clock, all state updates on the rising edge
//   i_rst        synchronous active-high reset
//   i_en         beat enable, one W-bit beat per cycle while high
//   i_init       1 = accumulate rs1+imm into the buffer, 0 = shift the buffer out
//   i_cfu_op     custom-function-unit operation in progress (masks o_lsb when CFU=1)
//   i_rs1_en     rs1 operand gate
//   i_imm_en     imm operand gate
//   i_clr_lsb    clear imm bit 0 on beat 0 (JALR target alignment)
//   i_sh_signed  sign-fill during shift-out
//   i_rs1        rs1 operand beat, LSB-first
//   i_imm        immediate operand beat, LSB-first
//   o_q          serial buffer output beat
//   o_last       final beat of a word while enabled
//   o_lsb        address bits [1:0]
//   o_dbus_adr   word-aligned data bus address
//   o_ext_rs1    full 32-bit buffer contents

module serv_bufreg_w #(
  parameter int W   = 1,
  parameter int CFU = 0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_init,
  input  logic         i_cfu_op,
  input  logic         i_rs1_en,
  input  logic         i_imm_en,
  input  logic         i_clr_lsb,
  input  logic         i_sh_signed,
  input  logic [W-1:0] i_rs1,
  input  logic [W-1:0] i_imm,
  output logic [W-1:0] o_q,
  output logic         o_last,
  output logic [1:0]   o_lsb,
  output logic [31:0]  o_dbus_adr,
  output logic [31:0]  o_ext_rs1
);

  localparam int BEATS = 32 / W;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [CW-1:0] cnt;
  logic          c_r;
  logic [31:0]   buf_q;

  logic [W-1:0]  rs1_m;
  logic [W-1:0]  imm_m;
  logic [W-1:0]  fill;
  logic [W:0]    sum;

  // Serial adder: one W-bit slice per beat, carry held in c_r between beats.
  always_comb begin
    rs1_m = i_rs1 & {W{i_rs1_en}};
    imm_m = i_imm & {W{i_imm_en}};
    // JALR targets drop bit 0; that bit only exists in beat 0.
    if ((cnt == '0) && i_clr_lsb) begin
      imm_m[0] = 1'b0;
    end
    sum  = {1'b0, rs1_m} + {1'b0, imm_m} + {{W{1'b0}}, c_r};
    fill = i_sh_signed ? {W{buf_q[31]}} : {W{1'b0}};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt   <= '0;
      c_r   <= 1'b0;
      buf_q <= '0;
    end else if (i_en) begin
      // Counter width equals log2(BEATS), so natural overflow is the wrap.
      cnt <= cnt + CW'(1);
      // Carry out of the final beat lands in c_r too; bit 32 is meaningless
      // and is dropped once the enable falls between words.
      c_r <= sum[W];
      if (i_init) begin
        buf_q <= {sum[W-1:0], buf_q[31:W]};
      end else begin
        buf_q <= {fill, buf_q[31:W]};
      end
    end else begin
      // An idle cycle breaks the carry chain.
      c_r <= 1'b0;
    end
  end

  assign o_q        = buf_q[W-1:0] & {W{i_en}};
  assign o_last     = i_en && (cnt == CW'(BEATS - 1));
  assign o_lsb      = ((CFU != 0) && i_cfu_op) ? 2'b00 : buf_q[1:0];
  assign o_dbus_adr = {buf_q[31:2], 2'b00};
  assign o_ext_rs1  = buf_q;

endmodule

// File: tb/tb_serv_bufreg_w.sv
// tb/tb_serv_bufreg_w.sv - self-checking bench for serv_bufreg_w at W=1, W=2 and W=4 (CFU=1)

module tb_serv_bufreg_w;

  logic        clk;
  logic        rst;
  logic [2:0]  en;
  logic        init, cfu_op, rs1_en, imm_en, clr_lsb, sh_signed;
  logic [0:0]  r1, i1;
  logic [1:0]  r2, i2;
  logic [3:0]  r4, i4;
  logic [0:0]  q1;
  logic [1:0]  q2;
  logic [3:0]  q4;
  logic        last [3];
  logic [1:0]  lsb  [3];
  logic [31:0] adr  [3];
  logic [31:0] ext  [3];

  logic [31:0] mbuf [3];
  int checks   = 0;
  int failures = 0;

  serv_bufreg_w #(.W(1), .CFU(0)) u_w1 (
    .i_clk(clk), .i_rst(rst), .i_en(en[0]), .i_init(init), .i_cfu_op(cfu_op),
    .i_rs1_en(rs1_en), .i_imm_en(imm_en), .i_clr_lsb(clr_lsb), .i_sh_signed(sh_signed),
    .i_rs1(r1), .i_imm(i1), .o_q(q1), .o_last(last[0]), .o_lsb(lsb[0]),
    .o_dbus_adr(adr[0]), .o_ext_rs1(ext[0])
  );

  serv_bufreg_w #(.W(2), .CFU(0)) u_w2 (
    .i_clk(clk), .i_rst(rst), .i_en(en[1]), .i_init(init), .i_cfu_op(cfu_op),
    .i_rs1_en(rs1_en), .i_imm_en(imm_en), .i_clr_lsb(clr_lsb), .i_sh_signed(sh_signed),
    .i_rs1(r2), .i_imm(i2), .o_q(q2), .o_last(last[1]), .o_lsb(lsb[1]),
    .o_dbus_adr(adr[1]), .o_ext_rs1(ext[1])
  );

  serv_bufreg_w #(.W(4), .CFU(1)) u_w4 (
    .i_clk(clk), .i_rst(rst), .i_en(en[2]), .i_init(init), .i_cfu_op(cfu_op),
    .i_rs1_en(rs1_en), .i_imm_en(imm_en), .i_clr_lsb(clr_lsb), .i_sh_signed(sh_signed),
    .i_rs1(r4), .i_imm(i4), .o_q(q4), .o_last(last[2]), .o_lsb(lsb[2]),
    .o_dbus_adr(adr[2]), .o_ext_rs1(ext[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] qget(input int d);
    case (d)
      0:       return {31'b0, q1};
      1:       return {30'b0, q2};
      default: return {28'b0, q4};
    endcase
  endfunction

  function automatic logic [1:0] exp_lsb(input int d);
    if (d == 2 && cfu_op) return 2'b00;
    return mbuf[d][1:0];
  endfunction

  task automatic set_ops(input int d, input logic [31:0] r, input logic [31:0] im, input int k);
    case (d)
      0: begin r1 = r[k];         i1 = im[k];         end
      1: begin r2 = r[2*k +: 2];  i2 = im[2*k +: 2];  end
      default: begin r4 = r[4*k +: 4]; i4 = im[4*k +: 4]; end
    endcase
  endtask

  task automatic check_word_outputs(input int d, input string tag);
    chk({tag, "_ext"}, ext[d], mbuf[d]);
    chk({tag, "_adr"}, adr[d], {mbuf[d][31:2], 2'b00});
    chk({tag, "_lsb"}, {30'b0, lsb[d]}, {30'b0, exp_lsb(d)});
  endtask

  // One full init word; an optional gap drops the enable before beat gap_at,
  // which splits the addition into two independent halves.
  task automatic init_word(input int d, input logic [31:0] r, input logic [31:0] im,
                           input bit re, input bit ie, input bit clr,
                           input int gap_at, input int gap_len, input string tag);
    int wd, nb, sh;
    logic [63:0] rm, imv, e;
    wd  = 1 << d;
    nb  = 32 / wd;
    rm  = re ? {32'b0, r}  : 64'd0;
    imv = ie ? {32'b0, im} : 64'd0;
    if (clr) imv[0] = 1'b0;
    if (gap_len > 0) begin
      sh = gap_at * wd;
      e  = ((rm + imv) & ((64'd1 << sh) - 64'd1)) | (((rm >> sh) + (imv >> sh)) << sh);
    end else begin
      e = rm + imv;
    end
    init = 1'b1; rs1_en = re; imm_en = ie; clr_lsb = clr; sh_signed = 1'b0;
    for (int k = 0; k < nb; k++) begin
      if (gap_len > 0 && k == gap_at) begin
        repeat (gap_len) begin
          @(negedge clk);
          en[d] = 1'b0;
          #1 chk({tag, "_gap_q"}, qget(d), 32'd0);
        end
      end
      @(negedge clk);
      set_ops(d, r, im, k);
      en[d] = 1'b1;
      #1 chk({tag, "_last"}, {31'b0, last[d]}, {31'b0, (k == nb - 1)});
    end
    @(negedge clk);
    en[d] = 1'b0;
    mbuf[d] = e[31:0];
    #1 check_word_outputs(d, tag);
  endtask

  task automatic shift_beats(input int d, input int n, input bit sgn, input string tag);
    int wd;
    logic [31:0] mask;
    wd   = 1 << d;
    mask = (32'd1 << wd) - 32'd1;
    init = 1'b0; sh_signed = sgn; rs1_en = 1'b0; imm_en = 1'b0; clr_lsb = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      set_ops(d, 32'd0, 32'd0, 0);
      en[d] = 1'b1;
      #1 chk({tag, "_q"}, qget(d), mbuf[d] & mask);
      mbuf[d] = sgn ? 32'($signed(mbuf[d]) >>> wd) : (mbuf[d] >> wd);
    end
    @(negedge clk);
    en[d] = 1'b0;
    #1 chk({tag, "_ext"}, ext[d], mbuf[d]);
  endtask

  task automatic check_reset_state(input string tag);
    for (int d = 0; d < 3; d++) begin
      mbuf[d] = 32'd0;
      check_word_outputs(d, tag);
      chk({tag, "_q"}, qget(d), 32'd0);
      chk({tag, "_last"}, {31'b0, last[d]}, 32'd0);
    end
  endtask

  initial begin
    int d;
    logic [31:0] r, im;
    rst = 1'b1; en = 3'b000; init = 1'b0; cfu_op = 1'b0; rs1_en = 1'b0; imm_en = 1'b0;
    clr_lsb = 1'b0; sh_signed = 1'b0;
    r1 = '0; i1 = '0; r2 = '0; i2 = '0; r4 = '0; i4 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check_reset_state("rst");

    // W=1 address add, o_last only on beat 31
    init_word(0, 32'h1000_0003, 32'h0000_0005, 1, 1, 0, 0, 0, "w1_add");
    chk("w1_add_adr_const", adr[0], 32'h1000_0008);

    // W=4 JALR-style clear of imm bit 0
    init_word(2, 32'h0000_0100, 32'h0000_0007, 1, 1, 1, 0, 0, "w4_clr");
    chk("w4_clr_const", ext[2], 32'h0000_0106);
    chk("w4_clr_lsb_const", {30'b0, lsb[2]}, 32'd2);

    // W=4 signed and unsigned shift-out of 0x8000_0000
    init_word(2, 32'h8000_0000, 32'h0, 1, 0, 0, 0, 0, "w4_ld");
    shift_beats(2, 1, 1'b1, "w4_sra1");
    chk("w4_sra1_const", ext[2], 32'hF800_0000);
    shift_beats(2, 7, 1'b1, "w4_sra7");
    init_word(2, 32'h8000_0000, 32'h0, 1, 0, 0, 0, 0, "w4_ld2");
    shift_beats(2, 1, 1'b0, "w4_srl1");
    chk("w4_srl1_const", ext[2], 32'h0800_0000);
    shift_beats(2, 7, 1'b0, "w4_srl7");

    // W=1 carry lost across a 3-cycle enable gap at beat 10
    init_word(0, 32'hFFFF_FFFF, 32'h0000_0001, 1, 1, 0, 10, 3, "w1_gap");
    chk("w1_gap_const", ext[0], 32'hFFFF_FC00);
    init_word(0, 32'h0, 32'h0, 1, 1, 0, 0, 0, "w1_fresh");

    // CFU masking of o_lsb on the W=4 instance only
    init_word(2, 32'h0000_0003, 32'h0, 1, 1, 0, 0, 0, "cfu_ld");
    init_word(0, 32'h0000_0003, 32'h0, 1, 1, 0, 0, 0, "cfu_ld1");
    cfu_op = 1'b1;
    #1 chk("cfu_on_w4", {30'b0, lsb[2]}, 32'd0);
    chk("cfu_on_w1", {30'b0, lsb[0]}, 32'd3);
    cfu_op = 1'b0;
    #1 chk("cfu_off_w4", {30'b0, lsb[2]}, 32'd3);

    // W=2 reset in the middle of a word
    init = 1'b1; rs1_en = 1'b1; imm_en = 1'b1; clr_lsb = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      set_ops(1, 32'hDEAD_BEEF, 32'h1234_5678, k);
      en[1] = 1'b1;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    en[1] = 1'b0;
    #1 check_reset_state("mid_rst");
    init_word(1, 32'h0000_0FF0, 32'h0000_0011, 1, 1, 0, 0, 0, "w2_after_rst");

    // Randomized words: random instance, operands, gates, clr, gap and shift mode
    for (int n = 0; n < 24; n++) begin
      d  = $urandom_range(0, 2);
      r  = $urandom;
      im = $urandom;
      cfu_op = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0)
        init_word(d, r, im, 1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(1, (32 >> d) - 1), $urandom_range(1, 3), "rnd_gap");
      else
        init_word(d, r, im, 1'($urandom), 1'($urandom), 1'($urandom), 0, 0, "rnd");
      shift_beats(d, 32 >> d, 1'($urandom), "rnd_sh");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serv_bufreg_w.md
SERV_BUFREG_W -- requirements
Module: serv_bufreg_w

Interface
REQ-001 The parameter W SHALL default to 1 and set the bits per beat; legal values are 1, 2, 4 and 8, giving 32/W beats per word.
REQ-002 The parameter CFU SHALL default to 0; when 1, o_lsb SHALL be forced to zero while i_cfu_op is high.
REQ-003 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_en  input  1  beat enable; the block advances one W-bit beat per cycle while high.
REQ-006 i_init  input  1  1 = accumulate rs1+imm into the buffer; 0 = shift the buffer out.
REQ-007 i_cfu_op  input  1  custom-function-unit operation in progress.
REQ-008 i_rs1_en, i_imm_en  input  1 each  operand gates.
REQ-009 i_clr_lsb  input  1  clear imm bit 0 on beat 0 (JALR).
REQ-010 i_sh_signed  input  1  sign-fill during shift-out.
REQ-011 i_rs1, i_imm  input  W each  serial operand beats, LSB-first.
REQ-012 o_q  output  W  serial buffer output beat.
REQ-013 o_last  output  1  high during the final beat (beat 32/W-1) of a word while i_en is high.
REQ-014 o_lsb  output  2  address bits [1:0].
REQ-015 o_dbus_adr  output  32  {buf[31:2], 2'b00}.
REQ-016 o_ext_rs1  output  32  full 32-bit buffer contents.

Function
REQ-017 The block SHALL hold a 32-bit buffer buf, a 1-bit carry c_r and a beat counter cnt of width log2(32/W).
REQ-018 cnt SHALL increment on every cycle with i_en high and wrap from 32/W-1 to 0; it SHALL hold when i_en is low.
REQ-019 Per beat, sum = (i_rs1 & {W{i_rs1_en}}) + (i_imm & {W{i_imm_en}} with bit 0 masked when cnt==0 and i_clr_lsb) + c_r; the sum is W+1 bits wide, the upper bit being carry-out.
REQ-020 c_r SHALL load the carry-out when i_en is high, and SHALL clear to 0 when i_en is low.
REQ-021 Carry-out of the last beat SHALL update c_r like any other beat; because the word then ends, the bit 32 overflow is discarded.
REQ-022 Init beat: buf <= {sum[W-1:0], buf[31:W]}; after 32/W beats buf holds rs1+imm mod 2^32.
REQ-023 Shift beat (i_init=0, i_en=1): buf <= {fill, buf[31:W]}, where fill is {W{buf[31]}} if i_sh_signed, else zero.
REQ-024 o_q SHALL equal buf[W-1:0] & {W{i_en}}, combinationally.
REQ-025 o_lsb SHALL equal buf[1:0], except that it SHALL be 2'b00 when CFU=1 and i_cfu_op=1.
REQ-026 With i_en low, buf and cnt SHALL hold; i_init and operand inputs SHALL be ignored.
REQ-027 Changing i_init mid-word SHALL not reset cnt; the next beat uses the new mode.

Reset
REQ-028 While i_rst is high at the clock edge, buf, c_r and cnt SHALL clear to 0, overriding i_en.
REQ-029 Resulting reset output values: o_q=0, o_last=0, o_lsb=0, o_dbus_adr=0, o_ext_rs1=0.
REQ-030 Reset asserted mid-word SHALL abandon the word; the next enabled beat is beat 0.

Structure
REQ-031 No shared package SHALL be used; the derived localparams (beat count and counter width) SHALL be local to the module.
REQ-032 The block SHALL be a single module with no sub-modules; the W-bit serial adder SHALL be inline.

Verification
REQ-033 With W=1: rs1=0x1000_0003, imm=0x0000_0005, both enables on, 32 init beats -> o_dbus_adr=0x1000_0008, o_lsb=0, o_last pulses on beat 31 only.
REQ-034 With W=4, clr_lsb=1: rs1=0x0000_0100, imm=0x0000_0007, 8 beats -> o_ext_rs1=0x0000_0106, o_lsb=2'b10.
REQ-035 With W=4: buf=0x8000_0000, shift beat with i_sh_signed=1 -> buf=0xF800_0000 and o_q=0x0; repeated with i_sh_signed=0 -> buf=0x0800_0000.
REQ-036 With W=1: rs1=0xFFFF_FFFF, imm=1, i_en dropped for 3 cycles at beat 10 -> carry is lost (c_r cleared); bench checks the documented truncated result, then checks that a fresh word starts with c_r=0.
REQ-037 With W=2: reset asserted at beat 5 -> all outputs are 0 on the next cycle and cnt restarts at 0.
REQ-038 With CFU=1: i_cfu_op=1 and buf[1:0]=2'b11 -> o_lsb=2'b00; with i_cfu_op=0 -> o_lsb=2'b11.
